// File: rtl/nios_mul_pipe.sv
// nios_mul_pipe: elastic multiply pipeline with valid/ready flow control.
// Returns the low product half (op 00) or the signed/unsigned high half
// (ops 01/10/11). A per-op tag travels with each operation.
// Optional feature macro: NIOS_MUL_PIPE_OVF_EN. When it is defined, out_ovf
// flags a signed overflow on op 00. When it is not defined, out_ovf is tied to 0.
//
// Handshake: a beat moves on any edge where valid && ready. A stage loads
// when it is empty or when the stage downstream of it loads. in_ready
// therefore falls only when every stage is full and out_ready is low.
// clr empties the pipe at the next edge. A beat presented with clr is dropped.
module nios_mul_pipe #(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2,
    parameter int TAG_W       = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [1:0]        in_op,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_ovf
);

    localparam int HALF_W = DATA_W / 2;

`ifdef NIOS_MUL_PIPE_OVF_EN
    // Op 00 is computed as a signed product so that the high half can be
    // used for overflow detection. The low half is the same either way.
    localparam logic SIGNED_LOW = 1'b1;
`else
    localparam logic SIGNED_LOW = 1'b0;
`endif

    // The four half-width partial products feed DSP-sized multipliers.
    // corr is the high-half sign correction:
    //   signed(a)*signed(b) = ua*ub - (sa?ub:0)<<W - (sb?ua:0)<<W  (mod 2^2W).
    typedef struct packed {
        logic [DATA_W-1:0] corr;
        logic [DATA_W-1:0] hh;
        logic [DATA_W-1:0] hl;
        logic [DATA_W-1:0] lh;
        logic [DATA_W-1:0] ll;
    } pp_t;

    function automatic pp_t make_pp(input logic [DATA_W-1:0] a,
                                    input logic [DATA_W-1:0] b,
                                    input logic [1:0]        op);
        pp_t               pp;
        logic              sa;
        logic              sb;
        logic [DATA_W-1:0] al;
        logic [DATA_W-1:0] ah;
        logic [DATA_W-1:0] bl;
        logic [DATA_W-1:0] bh;
        al = {{HALF_W{1'b0}}, a[HALF_W-1:0]};
        ah = {{HALF_W{1'b0}}, a[DATA_W-1:HALF_W]};
        bl = {{HALF_W{1'b0}}, b[HALF_W-1:0]};
        bh = {{HALF_W{1'b0}}, b[DATA_W-1:HALF_W]};
        sa = a[DATA_W-1] & ((op == 2'b01) | (op == 2'b10) | ((op == 2'b00) & SIGNED_LOW));
        sb = b[DATA_W-1] & ((op == 2'b01) | ((op == 2'b00) & SIGNED_LOW));
        pp.ll   = al * bl;
        pp.lh   = al * bh;
        pp.hl   = ah * bl;
        pp.hh   = ah * bh;
        pp.corr = (sa ? b : '0) + (sb ? a : '0);
        return pp;
    endfunction

    function automatic logic [2*DATA_W-1:0] full_prod(input pp_t pp);
        return {{DATA_W{1'b0}}, pp.ll}
             + ({{DATA_W{1'b0}}, pp.lh} << HALF_W)
             + ({{DATA_W{1'b0}}, pp.hl} << HALF_W)
             + {pp.hh, {DATA_W{1'b0}}}
             - {pp.corr, {DATA_W{1'b0}}};
    endfunction

    function automatic logic [DATA_W-1:0] pick_half(input logic [2*DATA_W-1:0] p,
                                                    input logic [1:0]          op);
        return (op == 2'b00) ? p[DATA_W-1:0] : p[2*DATA_W-1:DATA_W];
    endfunction

`ifdef NIOS_MUL_PIPE_OVF_EN
    // The product fits in signed DATA_W only if the top DATA_W+1 bits are
    // all equal, that is, if they are a sign extension.
    function automatic logic ovf_of(input logic [2*DATA_W-1:0] p, input logic [1:0] op);
        return (op == 2'b00) & ~((&p[2*DATA_W-1:DATA_W-1]) | ~(|p[2*DATA_W-1:DATA_W-1]));
    endfunction
`endif

    logic [PIPE_STAGES-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q   [PIPE_STAGES];
    logic [PIPE_STAGES-1:0] en;
    logic [PIPE_STAGES:0]   v_chain;
    logic [TAG_W-1:0]       t_chain [PIPE_STAGES+1];
    logic [DATA_W-1:0]      res_q;
`ifdef NIOS_MUL_PIPE_OVF_EN
    logic                   ovf_q;
`endif

    // Stage enables: a stage may load if it, or any stage below it, is empty,
    // or if the consumer is taking the output this cycle.
    always_comb begin
        logic acc;
        acc = out_ready;
        en  = '0;
        for (int s = PIPE_STAGES - 1; s >= 0; s--) begin
            acc   = acc | ~valid_q[s];
            en[s] = acc;
        end
    end

    // Upstream view of each stage. Index 0 is the input port.
    always_comb begin
        v_chain    = {valid_q, in_valid};
        t_chain[0] = in_tag;
        for (int s = 0; s < PIPE_STAGES; s++) begin
            t_chain[s+1] = tag_q[s];
        end
    end

    // Valid and tag shift chain. clr overrides any load.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            for (int s = 0; s < PIPE_STAGES; s++) begin
                tag_q[s] <= '0;
            end
        end else begin
            for (int s = 0; s < PIPE_STAGES; s++) begin
                if (en[s]) begin
                    valid_q[s] <= v_chain[s];
                    tag_q[s]   <= t_chain[s];
                end
            end
            if (clr) begin
                valid_q <= '0;
            end
        end
    end

    generate
        if (PIPE_STAGES == 1) begin : g_single
            logic [2*DATA_W-1:0] prod_in;

            // Single stage: the partial products are formed and summed in the same cycle.
            always_comb prod_in = full_prod(make_pp(in_a, in_b, in_op));

            // Output register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    res_q <= '0;
`ifdef NIOS_MUL_PIPE_OVF_EN
                    ovf_q <= 1'b0;
`endif
                end else if (en[0]) begin
                    res_q <= pick_half(prod_in, in_op);
`ifdef NIOS_MUL_PIPE_OVF_EN
                    ovf_q <= ovf_of(prod_in, in_op);
`endif
                end
            end
        end else begin : g_multi
            pp_t                 pp_q [PIPE_STAGES-1];
            logic [1:0]          op_q [PIPE_STAGES-1];
            logic [2*DATA_W-1:0] prod_last;

            // The partial products are summed just before the output register.
            always_comb prod_last = full_prod(pp_q[PIPE_STAGES-2]);

            // Partial-product stages, followed by the output register.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int s = 0; s < PIPE_STAGES - 1; s++) begin
                        pp_q[s] <= '0;
                        op_q[s] <= '0;
                    end
                    res_q <= '0;
`ifdef NIOS_MUL_PIPE_OVF_EN
                    ovf_q <= 1'b0;
`endif
                end else begin
                    if (en[0]) begin
                        pp_q[0] <= make_pp(in_a, in_b, in_op);
                        op_q[0] <= in_op;
                    end
                    for (int s = 1; s < PIPE_STAGES - 1; s++) begin
                        if (en[s]) begin
                            pp_q[s] <= pp_q[s-1];
                            op_q[s] <= op_q[s-1];
                        end
                    end
                    if (en[PIPE_STAGES-1]) begin
                        res_q <= pick_half(prod_last, op_q[PIPE_STAGES-2]);
`ifdef NIOS_MUL_PIPE_OVF_EN
                        ovf_q <= ovf_of(prod_last, op_q[PIPE_STAGES-2]);
`endif
                    end
                end
            end
        end
    endgenerate

    assign in_ready   = en[0];
    assign out_valid  = valid_q[PIPE_STAGES-1];
    assign out_tag    = tag_q[PIPE_STAGES-1];
    assign out_result = res_q;
`ifdef NIOS_MUL_PIPE_OVF_EN
    assign out_ovf    = ovf_q;
`else
    assign out_ovf    = 1'b0;
`endif

endmodule

// File: tb/tb_nios_mul_pipe.sv
// Bench for nios_mul_pipe with DATA_W=32, PIPE_STAGES=2 and TAG_W=5.
// It uses a vector table, hand-written flow-control sequences and random traffic.
// The results are checked against an arithmetic reference model.
module tb_nios_mul_pipe;
  localparam int W    = 32;
  localparam int P    = 2;
  localparam int TW   = 5;
  localparam int EXPW = W + TW + 1;
  localparam int NV   = 13;
`ifdef NIOS_MUL_PIPE_OVF_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          clr;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [1:0]    in_op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_result;
  logic [TW-1:0] out_tag;
  logic          out_ovf;

  int checks   = 0;
  int failures = 0;

  logic [EXPW-1:0] exp_q[$];
  logic            stall_prev;
  logic [EXPW-1:0] held;

  logic [W-1:0]    got_res [8];
  logic [TW-1:0]   got_tag [8];
  logic            got_ovf [8];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   op;
    logic [W-1:0] res;
    logic         ovf;
  } vec_t;
  vec_t vecs [NV];

  nios_mul_pipe #(.DATA_W(W), .PIPE_STAGES(P), .TAG_W(TW)) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_ovf(out_ovf)
  );

  // ---------------- clock / watchdog ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic logic [EXPW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] op, input logic [TW-1:0] tag);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    logic [2*W-1:0] p;
    logic [W-1:0]   res;
    logic           ovf;
    ea  = (op == 2'b01 || op == 2'b10) ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb  = (op == 2'b01) ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    p   = ea * eb;
    res = (op == 2'b00) ? p[W-1:0] : p[2*W-1:W];
    ovf = 1'b0;
`ifdef NIOS_MUL_PIPE_OVF_EN
    begin
      longint sp;
      sp  = longint'($signed(a)) * longint'($signed(b));
      ovf = (op == 2'b00) && (sp > 64'sd2147483647 || sp < -64'sd2147483648);
    end
`endif
    return {res, tag, ovf};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      check("in_ready_rule", in_ready, (out_ready || exp_q.size() < P));
      if (stall_prev && out_valid)
        check("stall_hold", {out_result, out_tag, out_ovf}, held);
      stall_prev = out_valid && !out_ready;
      held       = {out_result, out_tag, out_ovf};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", 1'b1, 1'b0);
        end else begin
          check("sb_beat", {out_result, out_tag, out_ovf}, exp_q.pop_front());
        end
      end
      if (clr) exp_q.delete();
      else if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_op, in_tag));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [1:0] op, input logic [TW-1:0] tag);
    logic ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    in_tag   = tag;
    in_valid = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("send_accept", ok, 1'b1);
  endtask

  task automatic collect(input int n);
    int cnt;
    cnt = 0;
    for (int k = 0; k < 40 && cnt < n; k++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        got_res[cnt] = out_result;
        got_tag[cnt] = out_tag;
        got_ovf[cnt] = out_ovf;
        cnt++;
      end
    end
    check("collect_count", cnt, n);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && exp_q.size() != 0; k++) @(negedge clk);
    check("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int  n;
    bit  done;
    vecs[0]  = '{32'h0001_0003, 32'h0002_0005, 2'b00, 32'h000B_000F, 1'b1};
    vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0002, 2'b10, 32'hFFFF_FFFF, 1'b0};
    vecs[3]  = '{32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 32'h0000_0001, 1'b0};
    vecs[4]  = '{32'h0000_0002, 32'h0000_0003, 2'b00, 32'h0000_0006, 1'b0};
    vecs[5]  = '{32'h0001_0000, 32'h0001_0000, 2'b00, 32'h0000_0000, 1'b1};
    vecs[6]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00, 32'h0000_0001, 1'b0};
    vecs[7]  = '{32'h8000_0000, 32'h8000_0000, 2'b01, 32'h4000_0000, 1'b0};
    vecs[8]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b11, 32'hFFFF_FFFE, 1'b0};
    vecs[9]  = '{32'h8000_0000, 32'hFFFF_FFFF, 2'b10, 32'h8000_0000, 1'b0};
    vecs[10] = '{32'h7FFF_FFFF, 32'h0000_0002, 2'b00, 32'hFFFF_FFFE, 1'b1};
    vecs[11] = '{32'hFFFF_8000, 32'h0001_0000, 2'b00, 32'h8000_0000, 1'b0};
    vecs[12] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 2'b01, 32'h3FFF_FFFF, 1'b0};

    reset_n   = 1'b1;
    clr       = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_op     = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    stall_prev = 1'b0;
    held       = '0;

    // Reset state.
    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_result", out_result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_ovf", out_ovf, 1'b0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;

    // Latency from the accept cycle to out_valid.
    send(32'h0001_0003, 32'h0002_0005, 2'b00, 5'd0);
    n = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    check("latency", n, P);
    check("lat_result", out_result, 32'h000B_000F);
    @(posedge clk);
    #1;

    // Vector table.
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].op, TW'(i));
      collect(1);
      check($sformatf("tbl%0d_res", i), got_res[0], vecs[i].res);
      check($sformatf("tbl%0d_tag", i), got_tag[0], TW'(i));
      check($sformatf("tbl%0d_ovf", i), got_ovf[0], vecs[i].ovf & OVF_ON);
    end

    // High-half ops issued back to back, with tags 1..3.
    fork
      begin
        send(32'hFFFF_FFFF, 32'h0000_0002, 2'b01, 5'd1);
        send(32'hFFFF_FFFF, 32'h0000_0002, 2'b10, 5'd2);
        send(32'hFFFF_FFFF, 32'h0000_0002, 2'b11, 5'd3);
      end
      collect(3);
    join
    check("b2b_tag0", got_tag[0], 5'd1);
    check("b2b_tag1", got_tag[1], 5'd2);
    check("b2b_tag2", got_tag[2], 5'd3);
    check("b2b_res0", got_res[0], 32'hFFFF_FFFF);
    check("b2b_res1", got_res[1], 32'hFFFF_FFFF);
    check("b2b_res2", got_res[2], 32'h0000_0001);

    // Backpressure: a full pipe must drop in_ready, lose nothing and keep order.
    fork
      begin
        for (int t = 0; t < 4; t++) send($urandom, $urandom, 2'b00, TW'(t));
      end
      begin
        for (int k = 0; k < 20; k++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("full_in_ready", in_ready, 1'b0);
        check("full_out_valid", out_valid, 1'b1);
        idle(2);
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight. The beat presented together with clr is dropped.
    out_ready = 1'b0;
    send(32'h0000_0011, 32'h0000_0013, 2'b00, 5'd5);
    send(32'h0000_0017, 32'h0000_001D, 2'b11, 5'd6);
    clr      = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'h0000_0003;
    in_b     = 32'h0000_0005;
    in_op    = 2'b00;
    in_tag   = 5'd7;
    @(posedge clk);
    #1;
    clr      = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("clr_out_valid", out_valid, 1'b0);
    check("clr_in_ready", in_ready, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("clr_nothing_out", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a stream.
    out_ready = 1'b0;
    send(32'h0000_0005, 32'h0000_0007, 2'b00, 5'd9);
    send(32'h0000_0009, 32'h0000_000B, 2'b00, 5'd10);
    check("pre_rst_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_result", out_result, 0);
    check("mid_rst_tag", out_tag, 0);
    check("mid_rst_ovf", out_ovf, 1'b0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    send(32'h0000_0002, 32'h0000_0003, 2'b00, 5'd4);
    collect(1);
    check("post_rst_res", got_res[0], 32'h0000_0006);
    check("post_rst_tag", got_tag[0], 5'd4);

    // Random traffic with random backpressure, checked by the scoreboard.
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          idle($urandom_range(0, 2));
          send(rand_operand(), rand_operand(), 2'($urandom_range(0, 3)), TW'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
